// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature decoder with glitch filter and position counter
//
// Synchronizes and filters encoder phases A/B, decodes every single-phase
// Gray-code edge into an up/down step of a loadable position counter, and
// raises a sticky error when both filtered phases change on the same edge.
//
// Ports:
//   clk       system clock, rising edge
//   areset    asynchronous active-high reset
//   qa, qb    encoder phases, asynchronous to clk
//   en        counting enable (phase tracking continues while low)
//   load      synchronous load of count from loaddata
//   loaddata  value written on load
//   err_clr   clears the sticky error flag
//   count     position, modulo 2^WIDTH
//   dir       direction of last counted step (1 = up)
//   step      one-cycle pulse per counted step
//   err       sticky illegal-transition flag

module quad_decoder #(
   parameter int WIDTH = 32,
   parameter int FILT  = 4
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             qa,
   input  logic             qb,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] loaddata,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             step,
   output logic             err
);

   localparam int              CW      = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [CW-1:0]   CNT_MAX = CW'(FILT - 1);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   // Position of a {a,b} pair along the forward Gray sequence 00-10-11-01.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      logic [1:0] p;
      case (ab)
         2'b00:   p = 2'd0;
         2'b10:   p = 2'd1;
         2'b11:   p = 2'd2;
         default: p = 2'd3;
      endcase
      return p;
   endfunction

   logic             sa1_q, sa1_d, sa_q, sa_d;
   logic             sb1_q, sb1_d, sb_q, sb_d;
   logic             fa_q, fa_d, fb_q, fb_d;
   logic [CW-1:0]    ca_q, ca_d, cb_q, cb_d;
   logic             primed_q, primed_d;
   logic [1:0]       init_q, init_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;

   logic [1:0]       old_ab, new_ab, chg, pos_next;
   logic             valid, illegal, is_up;

   always_comb begin
      sa1_d    = qa;
      sa_d     = sa1_q;
      sb1_d    = qb;
      sb_d     = sb1_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      ca_d     = ca_q;
      cb_d     = cb_q;
      primed_d = primed_q;
      init_d   = init_q;

      if (!primed_q) begin
         // Third edge after reset release: adopt the synchronized phases
         // as-is so a resting encoder never produces a step or an error.
         if (init_q == 2'd2) begin
            primed_d = 1'b1;
            fa_d     = sa_q;
            fb_d     = sb_q;
         end else begin
            init_d = init_q + 2'd1;
         end
      end else begin
         if (sa_q != fa_q) begin
            if (ca_q == CNT_MAX) begin
               fa_d = sa_q;
               ca_d = '0;
            end else begin
               ca_d = ca_q + 1'b1;
            end
         end else begin
            ca_d = '0;
         end

         if (sb_q != fb_q) begin
            if (cb_q == CNT_MAX) begin
               fb_d = sb_q;
               cb_d = '0;
            end else begin
               cb_d = cb_q + 1'b1;
            end
         end else begin
            cb_d = '0;
         end
      end
   end

   // Decode uses this cycle's filter result so the step lands on the same
   // edge as the filtered bit.
   always_comb begin
      old_ab   = {fa_q, fb_q};
      new_ab   = {fa_d, fb_d};
      chg      = old_ab ^ new_ab;
      pos_next = gray_pos(old_ab) + 2'd1;
      valid    = primed_q && ((chg == 2'b01) || (chg == 2'b10));
      illegal  = primed_q && (chg == 2'b11);
      is_up    = (gray_pos(new_ab) == pos_next);
   end

   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      err_d   = err_q;

      if (err_clr) begin
         err_d = 1'b0;
      end

      if (load) begin
         count_d = loaddata;
      end else if (en && valid) begin
         step_d = 1'b1;
         dir_d  = is_up;
         if (is_up) begin
            count_d = count_q + ONE;
         end else begin
            count_d = count_q - ONE;
         end
      end

      // Placed after err_clr so a same-cycle set wins.
      if (en && illegal) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         sa1_q    <= 1'b0;
         sa_q     <= 1'b0;
         sb1_q    <= 1'b0;
         sb_q     <= 1'b0;
         fa_q     <= 1'b0;
         fb_q     <= 1'b0;
         ca_q     <= '0;
         cb_q     <= '0;
         primed_q <= 1'b0;
         init_q   <= 2'd0;
         count_q  <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sa1_q    <= sa1_d;
         sa_q     <= sa_d;
         sb1_q    <= sb1_d;
         sb_q     <= sb_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         ca_q     <= ca_d;
         cb_q     <= cb_d;
         primed_q <= primed_d;
         init_q   <= init_d;
         count_q  <= count_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         err_q    <= err_d;
      end
   end

   assign count = count_q;
   assign dir   = dir_q;
   assign step  = step_q;
   assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed self-checking bench for quad_decoder

module tb_quad_decoder;

   localparam int WIDTH = 32;
   localparam int FILT  = 4;

   logic             clk = 1'b0;
   logic             areset = 1'b1;
   logic             qa = 1'b0;
   logic             qb = 1'b0;
   logic             en = 1'b1;
   logic             load = 1'b0;
   logic [WIDTH-1:0] loaddata = '0;
   logic             err_clr = 1'b0;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             step;
   logic             err;

   int n_checks = 0;
   int n_errors = 0;
   int steps_seen;
   int step_at;
   int err_seen;
   int total;

   quad_decoder #(.WIDTH(WIDTH), .FILT(FILT)) dut (
      .clk      (clk),
      .areset   (areset),
      .qa       (qa),
      .qb       (qb),
      .en       (en),
      .load     (load),
      .loaddata (loaddata),
      .err_clr  (err_clr),
      .count    (count),
      .dir      (dir),
      .step     (step),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive phases just after an edge, then watch step for a number of cycles.
   task automatic move(input logic a, input logic b, input int cycles);
      qa = a;
      qb = b;
      steps_seen = 0;
      step_at = 0;
      for (int i = 1; i <= cycles; i++) begin
         tick();
         if (step) begin
            steps_seen++;
            step_at = i;
         end
      end
   endtask

   initial begin
      tick();
      check_val("rst_count", count, 32'h0);
      check_val("rst_dir", 32'(dir), 32'h0);
      check_val("rst_step", 32'(step), 32'h0);
      check_val("rst_err", 32'(err), 32'h0);
      tick();
      areset = 1'b0;
      repeat (6) tick();

      // 16 forward edges, each step 6 cycles after the input change
      for (int k = 0; k < 16; k++) begin
         case (k % 4)
            0: move(1'b1, 1'b0, 8);
            1: move(1'b1, 1'b1, 8);
            2: move(1'b0, 1'b1, 8);
            default: move(1'b0, 1'b0, 8);
         endcase
         check_val($sformatf("fwd_nsteps_%0d", k), 32'(steps_seen), 32'd1);
         check_val($sformatf("fwd_step_at_%0d", k), 32'(step_at), 32'd6);
      end
      check_val("fwd_count", count, 32'd16);
      check_val("fwd_dir", 32'(dir), 32'd1);

      // load 0 then three reverse edges
      load = 1'b1;
      loaddata = 32'h0;
      tick();
      load = 1'b0;
      check_val("load0_count", count, 32'h0);
      move(1'b0, 1'b1, 8);
      move(1'b1, 1'b1, 8);
      move(1'b1, 1'b0, 8);
      check_val("rev_count", count, 32'hFFFF_FFFD);
      check_val("rev_dir", 32'(dir), 32'd0);

      // wrap from all-ones
      load = 1'b1;
      loaddata = 32'hFFFF_FFFF;
      tick();
      load = 1'b0;
      move(1'b1, 1'b1, 8);
      check_val("wrap_count", count, 32'h0);
      check_val("wrap_dir", 32'(dir), 32'd1);

      // 3-cycle qa glitch rejected
      move(1'b0, 1'b1, 3);
      total = steps_seen;
      move(1'b1, 1'b1, 10);
      total += steps_seen;
      check_val("glitch3_steps", 32'(total), 32'd0);
      check_val("glitch3_count", count, 32'h0);

      // 4-cycle qa pulse accepted, then returns
      move(1'b0, 1'b1, 4);
      move(1'b1, 1'b1, 2);
      check_val("pulse4_count_up", count, 32'd1);
      move(1'b1, 1'b1, 8);
      check_val("pulse4_count_back", count, 32'd0);
      check_val("pulse4_dir", 32'(dir), 32'd0);

      // move to 00, then illegal 00->11
      move(1'b0, 1'b1, 8);
      move(1'b0, 1'b0, 8);
      check_val("pre_illegal_count", count, 32'd2);
      move(1'b1, 1'b1, 8);
      check_val("illegal_err", 32'(err), 32'd1);
      check_val("illegal_count", count, 32'd2);
      check_val("illegal_steps", 32'(steps_seen), 32'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_val("errclr_err", 32'(err), 32'd0);

      // illegal 11->00 on the same edge as err_clr: set wins
      qa = 1'b0;
      qb = 1'b0;
      repeat (5) tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_val("set_vs_clr_err", 32'(err), 32'd1);
      check_val("set_vs_clr_count", count, 32'd2);
      repeat (3) tick();

      // load coinciding with forward edge 00->10
      qa = 1'b1;
      repeat (5) tick();
      load = 1'b1;
      loaddata = 32'h100;
      tick();
      load = 1'b0;
      check_val("load_edge_count", count, 32'h100);
      check_val("load_edge_step", 32'(step), 32'd0);
      repeat (3) tick();

      // en=0 keeps tracking without counting
      en = 1'b0;
      move(1'b1, 1'b1, 8);
      total = steps_seen;
      move(1'b0, 1'b1, 8);
      total += steps_seen;
      check_val("en0_steps", 32'(total), 32'd0);
      check_val("en0_count", count, 32'h100);
      en = 1'b1;
      move(1'b0, 1'b0, 8);
      check_val("en1_count", count, 32'h101);
      check_val("en1_steps", 32'(steps_seen), 32'd1);

      // set err, park at 11 with count 0x55, then async reset
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      move(1'b1, 1'b1, 8);
      check_val("pre_rst_err", 32'(err), 32'd1);
      load = 1'b1;
      loaddata = 32'h55;
      tick();
      load = 1'b0;
      check_val("pre_rst_count", count, 32'h55);
      areset = 1'b1;
      #1;
      check_val("arst_count", count, 32'h0);
      check_val("arst_err", 32'(err), 32'd0);
      tick();
      tick();
      areset = 1'b0;
      steps_seen = 0;
      err_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (step) steps_seen++;
         if (err) err_seen++;
      end
      check_val("post_rst_steps", 32'(steps_seen), 32'd0);
      check_val("post_rst_err", 32'(err_seen), 32'd0);
      check_val("post_rst_count", count, 32'h0);
      move(1'b0, 1'b1, 8);
      check_val("post_rst_fwd_count", count, 32'd1);
      check_val("post_rst_fwd_dir", 32'(dir), 32'd1);
      check_val("post_rst_fwd_steps", 32'(steps_seen), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
